imem_fetch_unit: RTL
====================

// Module: imem_fetch_unit
// PURPOSE
//  Parametrised instruction memory with a program-load port and a handshaked fetch port.
//  Successor to the fixed 64x32 combinational instruction store:
//   - depth, width and addressing mode are generic.
//   - Contents are loaded at run time, not hard-coded.
//   - Fetch has registered 1-cycle latency and reports faults.
//  Sits between the PC register and the decode stage of the single-cycle/multi-cycle MIPS core.
// PARAMETERS
//  DATA_W     32  instruction word width
//  DEPTH      64  number of words stored; any value >= 2
//  ADDR_W     32  fetch/load address width
//  BYTE_ADDR  1   1: if_addr is a byte address (index = addr>>2); 0: if_addr is a word index
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  init_done  out  1          1 once post-reset clear is complete
//  ld_valid   in   1          load request
//  ld_ready   out  1          load accepted when ld_valid & ld_ready
//  ld_idx     in   $clog2(DEPTH)  word index to write
//  ld_data    in   DATA_W     word to write
//  if_req     in   1          fetch request; single-cycle pulse or held
//  if_ready   out  1          fetch accepted when if_req & if_ready
//  if_addr    in   ADDR_W     fetch address
//  if_valid   out  1          response strobe, exactly 1 cycle after acceptance
//  if_instr   out  DATA_W     fetched word; 0 (NOP) on any fault
//  if_fault   out  2          00 OK, 01 MISALIGN, 10 OUT_OF_RANGE, 11 PARITY
// BEHAVIOUR
//  FSM states (imem_pkg::state_t): CLEAR, READY.
//  Reset:
//   - State goes to CLEAR, clear counter goes to 0.
//   - init_done, ld_ready, if_ready, if_valid reset to 0; if_instr and if_fault reset to 0.
//  CLEAR:
//   - Writes 0 to word[cnt], one word per cycle, cnt 0..DEPTH-1.
//   - At cnt == DEPTH-1: go to READY, init_done=1 next cycle. Duration is exactly DEPTH cycles.
//   - if_req and ld_valid are ignored (ready flags 0).
//  READY:
//   - ld_ready=1 and if_ready=1 continuously.
//   - Load writes mem[ld_idx] <= ld_data at the clock edge.
//  Fetch (accepted at edge N; response registered at edge N+1):
//   - idx = BYTE_ADDR ? if_addr>>2 : if_addr.
//   - Fault priority: MISALIGN, then OUT_OF_RANGE.
//     - MISALIGN: BYTE_ADDR=1 and if_addr[1:0] != 0.
//     - OUT_OF_RANGE: idx >= DEPTH, using the full address width with no truncation or wrap.
//   - if_valid=1 for one cycle per accepted request; back-to-back requests give back-to-back responses.
//   - With no request, if_valid=0 and if_instr/if_fault hold their last values.
//  Load and fetch in the same cycle:
//   - Both are accepted.
//   - Same index: fetch returns the OLD word (read-before-write).
//  ld_idx >= DEPTH (possible only when DEPTH is not a power of 2): write is dropped; ld_ready is still 1.
//  Reset mid-operation:
//   - An in-flight fetch is discarded; if_valid=0 on the cycle after reset.
//   - A pending load is not written.
//   - CLEAR restarts from cnt=0.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, computed on load; CLEAR stores parity 0.
//   - Fetch with mismatch: if_fault=11, if_instr=0.
//   - PARITY has the lowest fault priority.
//  IMEM_PARITY_EN undefined:
//   - No parity storage.
//   - Code 11 is never produced.
// STRUCTURE
//  imem_pkg:
//   - state_t enum {CLEAR, READY}.
//   - fault_t codes FLT_OK, FLT_MISALIGN, FLT_OOR, FLT_PARITY.
//   - NOP_WORD = 32'h0000_0000.
//  Sub-module imem_bank:
//   - DEPTH x (DATA_W + parity) array.
//   - One synchronous write port, one registered read port, read-before-write.
//  Top level:
//   - CLEAR/READY FSM and clear counter.
//   - Clear-vs-load write mux; CLEAR owns the write port.
//   - Address decode, fault logic, response registers.
// TESTING
//  1. Reset 1 cycle, DEPTH=64:
//     - init_done=0 and if_ready=0 for 64 cycles, then 1.
//     - Fetch addr 0x28 -> if_instr=0, if_fault=00.
//  2. Load idx 1 = 0x0213_402A; fetch addr 0x4 (BYTE_ADDR=1):
//     - Next cycle: if_valid=1, if_instr=0x0213_402A, if_fault=00.
//  3. Fetch addr 0x6 -> fault 01, instr 0.
//     Fetch addr 0x100 -> fault 10, instr 0.
//     Fetch addr 0x102 -> fault 01 (priority).
//  4. Same-cycle load idx 2 = 0x0800_0001 and fetch addr 0x8:
//     - Response is the old word 0.
//     - Next fetch of 0x8 returns 0x0800_0001.
//  5. BYTE_ADDR=0, DEPTH=48:
//     - Fetch addr 47 -> loaded word.
//     - Fetch addr 48 -> fault 10.
//     - Load ld_idx=50 -> no write, no hang.
//  6. Reset mid-stream:
//     - Reset asserted while a fetch is in flight -> if_valid=0 next cycle; mem re-cleared.
//     - IMEM_PARITY_EN: flip a stored bit via force -> fault 11, instr 0.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory fetch
//                unit: FSM state encoding, fetch fault codes, NOP word.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_OOR      = 2'b10,
    FLT_PARITY   = 2'b11
  } fault_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : imem_bank
//  Description : DEPTH x STORE_W storage array with one synchronous write
//                port and one registered read port. A read and a write to the
//                same index in the same cycle return the old word.
//  Ports       : clk, reset          clock / synchronous active-high reset
//                we, widx, wdata     write port
//                re, ridx            read request / index (caller keeps in range)
//                rdata               registered read data, reset to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_bank #(
  parameter int DEPTH   = 64,
  parameter int IDX_W   = 6,
  parameter int STORE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [STORE_W-1:0] wdata,
  input  logic               re,
  input  logic [IDX_W-1:0]   ridx,
  output logic [STORE_W-1:0] rdata
);

  logic [STORE_W-1:0] r_mem [DEPTH];
  logic [STORE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[widx] <= wdata;
    end
  end

  // Non-blocking read samples the pre-write contents: read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[ridx];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_unit
//  Description : Run-time loadable instruction memory with a handshaked,
//                1-cycle-latency fetch port and fault reporting. After reset
//                the array is cleared one word per cycle (CLEAR) before the
//                load and fetch ports open (READY).
//  Ports       : clk, reset                      clock / sync active-high reset
//                init_done                       array clear complete
//                ld_valid, ld_ready, ld_idx, ld_data   load port
//                if_req, if_ready, if_addr       fetch request
//                if_valid, if_instr, if_fault    fetch response
//  Config      : IMEM_PARITY_EN - store an even-parity bit per word and
//                report fault 11 on mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int BYTE_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_done,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     if_req,
  output logic                     if_ready,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_valid,
  output logic [DATA_W-1:0]        if_instr,
  output logic [1:0]               if_fault
);

  localparam int c_idx_w = $clog2(DEPTH);
  // Compare width wide enough for both the full address and DEPTH so the
  // range check never truncates or wraps.
  localparam int c_cmp_w = (ADDR_W > 32) ? ADDR_W : 32;
`ifdef IMEM_PARITY_EN
  localparam int c_par_w = 1;
`else
  localparam int c_par_w = 0;
`endif
  localparam int c_store_w = DATA_W + c_par_w;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // CLEAR / READY FSM
  // --------------------------------------------------------------------------
  state_t             r_state, w_state_next;
  logic [c_idx_w-1:0] r_cnt, w_cnt_next;
  logic               w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_state_next = READY;
          w_cnt_next   = '0;
        end
      end
      READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_next = CLEAR;
      end
    endcase
  end

  assign init_done = w_ready;
  assign ld_ready  = w_ready;
  assign if_ready  = w_ready;

  // --------------------------------------------------------------------------
  // Write port: the clear sweep owns the port while in CLEAR
  // --------------------------------------------------------------------------
  logic                 w_we;
  logic [c_idx_w-1:0]   w_widx;
  logic [c_store_w-1:0] w_wdata;
  logic                 w_ld_in_range;

  // Only reachable as false when DEPTH is not a power of two.
  assign w_ld_in_range = ({1'b0, ld_idx} < (c_idx_w + 1)'(DEPTH));

  always_comb begin
    w_we    = 1'b0;
    w_widx  = r_cnt;
    w_wdata = '0;
    if (!reset) begin
      if (r_state == CLEAR) begin
        w_we = 1'b1;
      end else if (ld_valid && w_ld_in_range) begin
        w_we   = 1'b1;
        w_widx = ld_idx;
`ifdef IMEM_PARITY_EN
        w_wdata = {^ld_data, ld_data};
`else
        w_wdata = ld_data;
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch address decode and fault classification
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_idx_full;
  logic              w_misalign;
  logic              w_oor;
  logic              w_accept;
  fault_t            w_fault_pre;

  assign w_idx_full = (BYTE_ADDR != 0) ? (if_addr >> 2) : if_addr;
  assign w_misalign = (BYTE_ADDR != 0) && (if_addr[1:0] != 2'b00);
  assign w_oor      = (c_cmp_w'(w_idx_full) >= c_cmp_w'(DEPTH));
  assign w_accept   = if_req && w_ready;

  always_comb begin
    w_fault_pre = FLT_OK;
    if (w_misalign) begin
      w_fault_pre = FLT_MISALIGN;
    end else if (w_oor) begin
      w_fault_pre = FLT_OOR;
    end
  end

  logic [c_store_w-1:0] w_rdata;

  imem_bank #(
    .DEPTH   (DEPTH),
    .IDX_W   (c_idx_w),
    .STORE_W (c_store_w)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .widx  (w_widx),
    .wdata (w_wdata),
    .re    (w_accept && (w_fault_pre == FLT_OK)),
    .ridx  (w_idx_full[c_idx_w-1:0]),
    .rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Response registers. The bank read register and r_fault_pre only update on
  // an accepted fetch, so the response holds between requests.
  // --------------------------------------------------------------------------
  logic   r_valid;
  fault_t r_fault_pre;
  logic   w_par_err;
  fault_t w_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_fault_pre <= FLT_OK;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_fault_pre <= w_fault_pre;
      end
    end
  end

  always_comb begin
    w_par_err = 1'b0;
`ifdef IMEM_PARITY_EN
    // Stored word plus parity bit has even weight when intact.
    w_par_err = ^w_rdata;
`endif
  end

  always_comb begin
    w_fault = r_fault_pre;
    if ((r_fault_pre == FLT_OK) && w_par_err) begin
      w_fault = FLT_PARITY;
    end
  end

  assign if_valid = r_valid;
  assign if_fault = w_fault;
  assign if_instr = (w_fault != FLT_OK) ? DATA_W'(NOP_WORD) : w_rdata[DATA_W-1:0];

endmodule
`default_nettype wire
